// File: rtl/wbs_regfifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wbs_regfifo_pkg
//  Description : Shared address map, cycle-type constants and decode helpers
//                for the Wishbone register file / mailbox FIFO slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package wbs_regfifo_pkg;

  localparam logic [4:0] ADDR_FIFO = 5'h10;
  localparam logic [4:0] ADDR_STAT = 5'h11;
  localparam logic [4:0] ADDR_ISR  = 5'h12;
  localparam logic [4:0] ADDR_IER  = 5'h13;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [2:0] {
    RGN_REG  = 3'd0,
    RGN_FIFO = 3'd1,
    RGN_STAT = 3'd2,
    RGN_ISR  = 3'd3,
    RGN_IER  = 3'd4,
    RGN_RSVD = 3'd5
  } region_e;

  // Map a word address onto the region it belongs to.
  function automatic region_e addr_region(input logic [4:0] a);
    if (!a[4]) return RGN_REG;
    case (a)
      ADDR_FIFO: return RGN_FIFO;
      ADDR_STAT: return RGN_STAT;
      ADDR_ISR:  return RGN_ISR;
      ADDR_IER:  return RGN_IER;
      default:   return RGN_RSVD;
    endcase
  endfunction

  // Replace only the byte lanes selected by sel (bit1 = upper byte).
  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [1:0]  sel);
    return {sel[1] ? new_v[15:8] : old_v[15:8],
            sel[0] ? new_v[7:0]  : old_v[7:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wbs_regfifo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wbs_sync_fifo
//  Description : Single-clock FIFO with occupancy count. Pushes while full and
//                pops while empty are ignored. Read data is the current head.
//  Revision    : 1.0 - initial release
// ============================================================================
module wbs_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wbs_regfifo.sv
`default_nettype none
// ============================================================================
//  Module      : wbs_regfifo
//  Description : Wishbone slave with sixteen general registers, a mailbox
//                FIFO with sticky overflow/underflow flags and, when the
//                WBS_IRQ_EN macro is defined, a maskable level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module wbs_regfifo
  import wbs_regfifo_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] REG_RESET  = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [15:0] wb_data_i,
  output logic [15:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_int_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          r_ack;
  logic          r_hold;
  logic [15:0]   r_data;
  logic [15:0]   r_regs [16];
  logic          r_ovf;
  logic          r_unf;
  logic          w_req;
  logic          w_ack_nxt;
  logic          w_wr;
  logic          w_rd;
  region_e       w_region;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_ev;
  logic          w_unf_ev;
  logic          w_stat_wr;
  logic [15:0]   w_fifo_dout;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [15:0]   w_rdata;
  logic [15:0]   w_isr_rd;
  logic [15:0]   w_ier_rd;

  // r_hold blocks a repeat ack for a single access while stb stays high; it
  // comes out of reset set so the first ack needs a strobe seen after reset.
  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_ack_nxt = w_req & ~r_hold & (~r_ack | (wb_cti_i == CTI_CONST));
  assign w_wr      = w_ack_nxt & wb_we_i;
  assign w_rd      = w_ack_nxt & ~wb_we_i;
  assign w_region  = addr_region(wb_addr_i);

  assign w_push    = w_wr & (w_region == RGN_FIFO) & ~w_full;
  assign w_ovf_ev  = w_wr & (w_region == RGN_FIFO) & w_full;
  assign w_pop     = w_rd & (w_region == RGN_FIFO) & ~w_empty;
  assign w_unf_ev  = w_rd & (w_region == RGN_FIFO) & w_empty;
  assign w_stat_wr = w_wr & (w_region == RGN_STAT) & wb_sel_i[1];

  assign wb_ack_o  = r_ack;
  assign wb_data_o = r_data;

  // Unselected byte lanes are pushed as zero.
  wbs_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (lane_merge(16'h0000, wb_data_i, wb_sel_i)),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Acknowledge generation plus the one-ack-per-single-access guard.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack  <= 1'b0;
      r_hold <= 1'b1;
    end else begin
      r_ack <= w_ack_nxt;
      if (!w_req)
        r_hold <= 1'b0;
      else if (w_ack_nxt && (wb_cti_i != CTI_CONST))
        r_hold <= 1'b1;
    end
  end

  // Read data mux for the addressed location.
  always_comb begin
    w_rdata = 16'h0000;
    case (w_region)
      RGN_REG:  w_rdata = r_regs[wb_addr_i[3:0]];
      RGN_FIFO: w_rdata = w_empty ? 16'h0000 : w_fifo_dout;
      RGN_STAT: w_rdata = {r_unf, r_ovf, w_full, w_empty, 3'b000, 9'(w_count)};
      RGN_ISR:  w_rdata = w_isr_rd;
      RGN_IER:  w_rdata = w_ier_rd;
      default:  w_rdata = 16'h0000;
    endcase
  end

  // Read data is captured with each ack and held otherwise.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)    r_data <= 16'h0000;
    else if (w_ack_nxt) r_data <= w_rdata;
  end

  // General registers with byte-lane write enables.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= REG_RESET;
    end else if (w_wr && (w_region == RGN_REG)) begin
      r_regs[wb_addr_i[3:0]] <= lane_merge(r_regs[wb_addr_i[3:0]], wb_data_i, wb_sel_i);
    end
  end

  // Sticky FIFO error flags; a new event in the clearing cycle wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_stat_wr && wb_data_i[15]) r_unf <= 1'b0;
      if (w_stat_wr && wb_data_i[14]) r_ovf <= 1'b0;
      if (w_unf_ev) r_unf <= 1'b1;
      if (w_ovf_ev) r_ovf <= 1'b1;
    end
  end

`ifdef WBS_IRQ_EN
  logic [2:0] r_isr;
  logic [2:0] r_ier;
  logic       r_int;
  logic [2:0] w_isr_clr;
  logic [2:0] w_isr_set;

  // A push while empty is exactly the rising edge of not-empty.
  assign w_isr_set = {w_unf_ev, w_ovf_ev, w_push & w_empty};
  assign w_isr_clr = (w_wr && (w_region == RGN_ISR) && wb_sel_i[0]) ? wb_data_i[2:0] : 3'b000;
  assign w_isr_rd  = {13'h0000, r_isr};
  assign w_ier_rd  = {13'h0000, r_ier};
  assign wb_int_o  = r_int;

  // Interrupt status (sticky, write-1-to-clear), enable, and registered line.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_isr <= 3'b000;
      r_ier <= 3'b000;
      r_int <= 1'b0;
    end else begin
      r_isr <= (r_isr & ~w_isr_clr) | w_isr_set;
      if (w_wr && (w_region == RGN_IER) && wb_sel_i[0]) r_ier <= wb_data_i[2:0];
      r_int <= |(r_isr & r_ier);
    end
  end
`else
  assign w_isr_rd = 16'h0000;
  assign w_ier_rd = 16'h0000;
  assign wb_int_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wbs_regfifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wbs_regfifo
//  Description : Self-checking bench for wbs_regfifo: directed scenarios plus
//                random classic/burst traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wbs_regfifo;

  localparam int          DEPTH   = 16;
  localparam logic [15:0] REG_RST = 16'h5A3C;
`ifdef WBS_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [4:0]  addr = '0;
  logic [1:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        ack;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [15:0] m_regs [16];
  logic [15:0] m_fifo [$];
  bit          m_unf, m_ovf;
  logic [2:0]  m_isr, m_ier;

  always #5 clk = ~clk;

  wbs_regfifo #(
    .FIFO_DEPTH (DEPTH),
    .REG_RESET  (REG_RST)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_addr_i  (addr),
    .wb_sel_i   (sel),
    .wb_cti_i   (cti),
    .wb_data_i  (din),
    .wb_data_o  (dout),
    .wb_ack_o   (ack),
    .wb_int_o   (irq)
  );

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = REG_RST;
    m_fifo.delete();
    m_unf = 0; m_ovf = 0; m_isr = 3'b000; m_ier = 3'b000;
  endtask

  function automatic logic expect_int();
    return IRQ ? |(m_isr & m_ier) : 1'b0;
  endfunction

  // One acknowledged beat: returns read data and applies side effects.
  function automatic logic [15:0] model_beat(input bit w, input logic [4:0] a,
                                             input logic [15:0] d, input logic [1:0] s);
    logic [15:0] rv;
    logic [15:0] pd;
    rv = 16'h0000;
    if (a < 5'h10) begin
      rv = m_regs[a[3:0]];
      if (w) begin
        if (s[1]) m_regs[a[3:0]][15:8] = d[15:8];
        if (s[0]) m_regs[a[3:0]][7:0]  = d[7:0];
      end
    end else if (a == 5'h10) begin
      if (w) begin
        pd = 16'h0000;
        if (s[1]) pd[15:8] = d[15:8];
        if (s[0]) pd[7:0]  = d[7:0];
        if (m_fifo.size() == DEPTH) begin
          m_ovf = 1;
          if (IRQ) m_isr[1] = 1'b1;
        end else begin
          if (m_fifo.size() == 0 && IRQ) m_isr[0] = 1'b1;
          m_fifo.push_back(pd);
        end
      end else if (m_fifo.size() == 0) begin
        m_unf = 1;
        if (IRQ) m_isr[2] = 1'b1;
      end else begin
        rv = m_fifo.pop_front();
      end
    end else if (a == 5'h11) begin
      rv = {m_unf, m_ovf, m_fifo.size() == DEPTH, m_fifo.size() == 0, 3'b000, 9'(m_fifo.size())};
      if (w && s[1]) begin
        if (d[15]) m_unf = 0;
        if (d[14]) m_ovf = 0;
      end
    end else if (a == 5'h12 && IRQ) begin
      rv = {13'h0000, m_isr};
      if (w && s[0]) m_isr = m_isr & ~d[2:0];
    end else if (a == 5'h13 && IRQ) begin
      rv = {13'h0000, m_ier};
      if (w && s[0]) m_ier = d[2:0];
    end
    return rv;
  endfunction

  task automatic push_exp(input bit w, input logic [4:0] a, input logic [15:0] d, input logic [1:0] s);
    exp_t e;
    e.rd   = !w;
    e.data = model_beat(w, a, d, s);
    sb.push_back(e);
  endtask

  // Monitor: every ack pops one expected beat; read beats compare data.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd) begin
          checks++;
          if (dout !== e.data) begin
            errors++;
            $display("FAIL read_data: got %h expected %h at %0t", dout, e.data, $time);
          end
        end
      end
    end
  end

  // Single access; stb is held 'hold' extra cycles after the ack.
  task automatic classic(input bit w, input logic [4:0] a, input logic [15:0] d,
                         input logic [1:0] s, input int hold, input logic [2:0] c);
    push_exp(w, a, d, s);
    cyc = 1; stb = 1; we = w; addr = a; din = d; sel = s; cti = c;
    @(posedge clk); #1;
    check("ack_latency", {15'h0, ack}, 16'h0001);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("single_ack", {15'h0, ack}, 16'h0000);
    end
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    check("int_level", {15'h0, irq}, {15'h0, expect_int()});
  endtask

  // Constant-address burst of n beats; data is base+i or random.
  task automatic burst(input bit w, input logic [4:0] a, input int n,
                       input logic [15:0] base, input bit rnd);
    cyc = 1; stb = 1; we = w; addr = a; sel = 2'b11; cti = 3'b001;
    for (int i = 0; i < n; i++) begin
      din = rnd ? 16'($urandom) : base + 16'(i);
      push_exp(w, a, din, sel);
      @(posedge clk); #1;
      check("burst_ack", {15'h0, ack}, 16'h0001);
    end
    cyc = 0; stb = 0; we = 0; cti = 3'b000;
    @(posedge clk); #1;
    check("burst_end", {15'h0, ack}, 16'h0000);
    check("int_level", {15'h0, irq}, {15'h0, expect_int()});
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_ack", {15'h0, ack}, 16'h0000);
    check("rst_data", dout, 16'h0000);
    check("rst_int", {15'h0, irq}, 16'h0000);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Register write/read and byte-lane writes
    classic(1, 5'h03, 16'hA5C3, 2'b11, 0, 3'b000);
    classic(0, 5'h03, 16'h0000, 2'b11, 0, 3'b000);
    check("reg_rw", dout, 16'hA5C3);
    classic(1, 5'h05, 16'hFFFF, 2'b11, 0, 3'b000);
    classic(1, 5'h05, 16'h1234, 2'b01, 2, 3'b000);
    classic(0, 5'h05, 16'h0000, 2'b11, 0, 3'b111);
    check("reg_lane", dout, 16'hFF34);
    classic(0, 5'h1A, 16'h0000, 2'b11, 0, 3'b000);
    check("reserved_rd", dout, 16'h0000);

    // Fill, overflow, drain, underflow
    burst(1, 5'h10, 16, 16'h0000, 0);
    classic(0, 5'h11, 16'h0000, 2'b11, 0, 3'b000);
    check("stat_full", dout, 16'h2010);
    classic(1, 5'h10, 16'h00AA, 2'b11, 0, 3'b000);
    classic(0, 5'h11, 16'h0000, 2'b11, 0, 3'b000);
    check("stat_ovf", dout, 16'h6010);
    burst(0, 5'h10, 16, 16'h0000, 0);
    check("last_pop", dout, 16'h000F);
    classic(0, 5'h10, 16'h0000, 2'b11, 0, 3'b000);
    check("unf_rd", dout, 16'h0000);
    classic(0, 5'h11, 16'h0000, 2'b11, 0, 3'b000);
    check("stat_unf", dout, 16'hD000);
    classic(1, 5'h11, 16'hC000, 2'b10, 0, 3'b000);
    classic(0, 5'h11, 16'h0000, 2'b11, 0, 3'b000);
    check("stat_clr", dout, 16'h1000);

    // Interrupt path
    classic(1, 5'h12, 16'h0007, 2'b11, 0, 3'b000);
    classic(1, 5'h13, 16'h0001, 2'b11, 0, 3'b000);
    classic(1, 5'h10, 16'hBEEF, 2'b11, 0, 3'b000);
    check("irq_raise", {15'h0, irq}, IRQ ? 16'h0001 : 16'h0000);
    classic(1, 5'h12, 16'h0001, 2'b11, 0, 3'b000);
    check("irq_clear", {15'h0, irq}, 16'h0000);
    classic(0, 5'h13, 16'h0000, 2'b11, 0, 3'b000);
    check("ier_rd", dout, IRQ ? 16'h0001 : 16'h0000);
    classic(0, 5'h10, 16'h0000, 2'b11, 0, 3'b000);
    check("fifo_rd", dout, 16'hBEEF);

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      int r;
      logic [4:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? 5'(5'h10 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      if (r < 6)
        classic($urandom_range(0, 1) == 1, a, 16'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 2), ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000);
      else
        burst($urandom_range(0, 1) == 1, (r == 9) ? a : 5'h10, $urandom_range(1, 20), 16'h0000, 1);
    end

    // Reset in the middle of a write burst
    classic(1, 5'h00, 16'h1111, 2'b11, 0, 3'b000);
    cyc = 1; stb = 1; we = 1; addr = 5'h10; sel = 2'b11; cti = 3'b001;
    for (int i = 0; i < 3; i++) begin
      din = 16'h7000 + 16'(i);
      push_exp(1, 5'h10, din, sel);
      @(posedge clk); #1;
      check("abort_ack", {15'h0, ack}, 16'h0001);
    end
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    model_reset();
    check("rst_mid_ack", {15'h0, ack}, 16'h0000);
    check("rst_mid_data", dout, 16'h0000);
    check("rst_mid_int", {15'h0, irq}, 16'h0000);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_stale_ack", {15'h0, ack}, 16'h0000);
    end
    cyc = 0; stb = 0; we = 0; cti = 3'b000;
    @(posedge clk); #1;
    classic(0, 5'h00, 16'h0000, 2'b11, 0, 3'b000);
    check("post_rst_reg", dout, REG_RST);
    classic(0, 5'h11, 16'h0000, 2'b11, 0, 3'b000);
    check("post_rst_stat", dout, 16'h1000);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 16'(sb.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
